// File: rtl/ascii8_mapper.sv
// ASCII8 MegaROM cartridge mapper: four 8 KiB bank registers, window decode,
// and a req/ack ROM fetch that stretches the Z80 cycle with WAIT_n.
module ascii8_mapper #(
    parameter int unsigned ROM_ADDR_WIDTH = 20
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      SLTSL_n,
    input  logic                      MERQ_n,
    input  logic                      RD_n,
    input  logic                      WR_n,
    input  logic                      RFSH_n,
    input  logic [15:0]               ADDR,
    input  logic [7:0]                DIN,
    input  logic                      RESET_n,
    output logic [7:0]                DOUT,
    output logic                      BUSDIR_n,
    output logic                      WAIT_n,
    output logic                      INT_n,
    output logic                      MEM_REQ,
    output logic [ROM_ADDR_WIDTH-1:0] MEM_ADDR,
    input  logic                      MEM_ACK,
    input  logic [7:0]                MEM_RDATA
);

    localparam int unsigned BANK_W     = ROM_ADDR_WIDTH - 13;
    localparam logic [7:0]  DRAIN_LAST = 8'd254;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_e;

    state_e                      state_q, state_d;
    logic [3:0][BANK_W-1:0]      bank_q, bank_d;
    logic                        prev_wr_q, prev_wr_d;
    logic                        prev_rd_q, prev_rd_d;
    logic [7:0]                  drain_cnt_q, drain_cnt_d;
    logic                        mem_req_q, mem_req_d;
    logic [ROM_ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]                  dout_q, dout_d;
    logic                        busdir_n_q, busdir_n_d;
    logic                        wait_n_q, wait_n_d;

    logic       wr_c, rd_c, wr_edge_c, rd_edge_c, in_window_c, bank_sel_c;
    logic [1:0] win_idx_c;

    assign wr_c        = SLTSL_n | MERQ_n | WR_n;
    assign rd_c        = SLTSL_n | MERQ_n | RD_n | ~RFSH_n;
    assign wr_edge_c   = prev_wr_q & ~wr_c;
    assign rd_edge_c   = prev_rd_q & ~rd_c;
    assign in_window_c = (ADDR[15:13] >= 3'd2) && (ADDR[15:13] <= 3'd5);
    assign win_idx_c   = 2'(ADDR[15:13] - 3'd2);
    assign bank_sel_c  = (ADDR[15:13] == 3'b011);

    // Next-state, bank update and registered-output computation
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        prev_wr_d   = wr_c;
        prev_rd_d   = rd_c;
        drain_cnt_d = drain_cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        dout_d      = dout_q;
        busdir_n_d  = busdir_n_q;
        wait_n_d    = wait_n_q;

        if (wr_edge_c && bank_sel_c) begin
            bank_d[ADDR[12:11]] = BANK_W'(DIN);
        end

        unique case (state_q)
            S_IDLE: begin
                if (rd_edge_c && in_window_c) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {bank_q[win_idx_c], ADDR[12:0]};
                    wait_n_d   = 1'b0;
                end
            end
            S_REQ: begin
                if (MEM_ACK) begin
                    mem_req_d = 1'b0;
                    wait_n_d  = 1'b1;
                    if (!rd_c) begin
                        state_d    = S_HOLD;
                        dout_d     = MEM_RDATA;
                        busdir_n_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (rd_c) begin
                    state_d    = S_IDLE;
                    dout_d     = 8'h00;
                    busdir_n_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (MEM_ACK || (drain_cnt_q == DRAIN_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
        endcase

        // Slot-bus reset: an in-flight fetch must swallow its late acknowledge
        if (!RESET_n) begin
            bank_d     = '0;
            prev_wr_d  = 1'b1;
            prev_rd_d  = 1'b1;
            mem_req_d  = 1'b0;
            mem_addr_d = '0;
            dout_d     = 8'h00;
            busdir_n_d = 1'b1;
            wait_n_d   = 1'b1;
            if (state_q == S_REQ) begin
                state_d     = MEM_ACK ? S_IDLE : S_DRAIN;
                drain_cnt_d = 8'd0;
            end else if (state_q != S_DRAIN) begin
                state_d     = S_IDLE;
                drain_cnt_d = 8'd0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            bank_q      <= '0;
            prev_wr_q   <= 1'b1;
            prev_rd_q   <= 1'b1;
            drain_cnt_q <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            dout_q      <= 8'h00;
            busdir_n_q  <= 1'b1;
            wait_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            prev_wr_q   <= prev_wr_d;
            prev_rd_q   <= prev_rd_d;
            drain_cnt_q <= drain_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            dout_q      <= dout_d;
            busdir_n_q  <= busdir_n_d;
            wait_n_q    <= wait_n_d;
        end
    end

    assign DOUT     = dout_q;
    assign BUSDIR_n = busdir_n_q;
    assign WAIT_n   = wait_n_q;
    assign INT_n    = 1'b1;
    assign MEM_REQ  = mem_req_q;
    assign MEM_ADDR = mem_addr_q;

endmodule

// File: tb/tb_ascii8_mapper.sv
// Self-checking bench for ascii8_mapper: vector table of banked reads plus
// hand-written reset, abort, drain and in-flight bank-write sequences.
module tb_ascii8_mapper;

    logic        CLK = 1'b0;
    logic        RESET, SLTSL_n, MERQ_n, RD_n, WR_n, RFSH_n, RESET_n;
    logic [15:0] ADDR;
    logic [7:0]  DIN;
    logic [7:0]  DOUT;
    logic        BUSDIR_n, WAIT_n, INT_n, MEM_REQ;
    logic [19:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [7:0]  MEM_RDATA;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  rdata;
        int          delay;
        logic [19:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [19:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];

    ascii8_mapper #(.ROM_ADDR_WIDTH(20)) dut (
        .CLK(CLK), .RESET(RESET), .SLTSL_n(SLTSL_n), .MERQ_n(MERQ_n),
        .RD_n(RD_n), .WR_n(WR_n), .RFSH_n(RFSH_n), .ADDR(ADDR), .DIN(DIN),
        .RESET_n(RESET_n), .DOUT(DOUT), .BUSDIR_n(BUSDIR_n), .WAIT_n(WAIT_n),
        .INT_n(INT_n), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_idle();
        SLTSL_n = 1'b1; MERQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1; RFSH_n = 1'b1;
    endtask

    task automatic sync_reset();
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); RESET = 1'b0;
    endtask

    task automatic bank_wr(input logic [15:0] a, input logic [7:0] v);
        @(negedge CLK); ADDR = a; DIN = v; SLTSL_n = 1'b0; MERQ_n = 1'b0; WR_n = 1'b0;
        @(negedge CLK); bus_idle();
    endtask

    // Full read: scoreboard entry pushed on the rd strobe, popped when MEM_REQ appears
    task automatic do_read(input logic [15:0] a, input logic [7:0] d, input int dly,
                           input logic [19:0] ea);
        exp_t e;
        int   wcnt;
        e = '{20'h0, 8'h0};
        @(negedge CLK);
        ADDR = a; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
        sb.push_back('{ea, d});
        wcnt = 0;
        for (int c = 0; c < dly; c++) begin
            @(negedge CLK);
            if (!WAIT_n) wcnt++;
            if (c == 0) begin
                e = sb.pop_front();
                chk("req_asserted", 32'(MEM_REQ), 32'd1);
                chk("req_addr", 32'(MEM_ADDR), 32'(e.addr));
            end
            if (c == dly - 1) begin
                chk("addr_stable", 32'(MEM_ADDR), 32'(e.addr));
                MEM_ACK = 1'b1; MEM_RDATA = d;
            end
        end
        @(negedge CLK);
        MEM_ACK = 1'b0; MEM_RDATA = 8'h00;
        if (!WAIT_n) wcnt++;
        chk("wait_cycles", 32'(wcnt), 32'(dly));
        chk("read_data", 32'(DOUT), 32'(e.data));
        chk("busdir_drive", 32'(BUSDIR_n), 32'd0);
        chk("req_dropped", 32'(MEM_REQ), 32'd0);
        @(negedge CLK);
        chk("data_hold", 32'(DOUT), 32'(e.data));
        bus_idle();
        @(negedge CLK);
        chk("release_dout", 32'(DOUT), 32'd0);
        chk("release_busdir", 32'(BUSDIR_n), 32'd1);
    endtask

    task automatic no_resp(input logic [15:0] a, input logic rfsh_n);
        @(negedge CLK);
        ADDR = a; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0; RFSH_n = rfsh_n;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("no_req", 32'(MEM_REQ), 32'd0);
            chk("no_busdir", 32'(BUSDIR_n), 32'd1);
        end
        bus_idle();
    endtask

    vec_t vecs[6];
    exp_t e;

    initial begin
        vecs[0] = '{16'h4001, 8'h11, 1,  20'h0A001};
        vecs[1] = '{16'h6002, 8'h22, 2,  20'h22002};
        vecs[2] = '{16'h9FFF, 8'h33, 3,  20'hFFFFF};
        vecs[3] = '{16'hA000, 8'hA5, 10, 20'h06000};
        vecs[4] = '{16'h5FFF, 8'h5A, 4,  20'h0BFFF};
        vecs[5] = '{16'hBFFF, 8'hC3, 1,  20'h07FFF};

        RESET = 1'b1; RESET_n = 1'b1; ADDR = 16'h0; DIN = 8'h0;
        MEM_ACK = 1'b0; MEM_RDATA = 8'h0;
        bus_idle();
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_mem_req", 32'(MEM_REQ), 32'd0);
        chk("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        chk("rst_busdir", 32'(BUSDIR_n), 32'd1);
        chk("rst_wait", 32'(WAIT_n), 32'd1);
        chk("rst_dout", 32'(DOUT), 32'd0);
        chk("int_n", 32'(INT_n), 32'd1);
        do_read(16'h4123, 8'h3C, 1, 20'h00123);

        // Bank map, including truncation of 0x83 to 0x03
        bank_wr(16'h6000, 8'h05);
        bank_wr(16'h6800, 8'h11);
        bank_wr(16'h7000, 8'h7F);
        bank_wr(16'h7800, 8'h83);
        foreach (vecs[i]) do_read(vecs[i].addr, vecs[i].rdata, vecs[i].delay, vecs[i].exp_addr);

        // Outside the window, refresh, and a non-register write
        no_resp(16'h0000, 1'b1);
        no_resp(16'hC000, 1'b1);
        no_resp(16'h4000, 1'b0);
        bank_wr(16'h5000, 8'h00);
        do_read(16'h4001, 8'h77, 1, 20'h0A001);
        do_read(16'hA000, 8'h78, 2, 20'h06000);

        // Aborted cycle: rd released before the acknowledge
        @(negedge CLK); ADDR = 16'h4002; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
        @(negedge CLK); chk("abort_req", 32'(MEM_REQ), 32'd1); bus_idle();
        @(negedge CLK); chk("abort_req_held", 32'(MEM_REQ), 32'd1); MEM_ACK = 1'b1; MEM_RDATA = 8'hEE;
        @(negedge CLK); MEM_ACK = 1'b0;
        chk("abort_req_drop", 32'(MEM_REQ), 32'd0);
        chk("abort_busdir", 32'(BUSDIR_n), 32'd1);
        chk("abort_wait", 32'(WAIT_n), 32'd1);
        chk("abort_dout", 32'(DOUT), 32'd0);
        do_read(16'h6002, 8'h44, 1, 20'h22002);

        // Bank write while a fetch is pending keeps the latched address
        sync_reset();
        @(negedge CLK); ADDR = 16'h4010; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
        sb.push_back('{20'h00010, 8'h4E});
        @(negedge CLK);
        e = sb.pop_front();
        chk("inflight_req", 32'(MEM_REQ), 32'd1);
        chk("inflight_addr", 32'(MEM_ADDR), 32'(e.addr));
        ADDR = 16'h6000; DIN = 8'h02; WR_n = 1'b0;
        @(negedge CLK);
        chk("inflight_addr_kept", 32'(MEM_ADDR), 32'(e.addr));
        WR_n = 1'b1; ADDR = 16'h4010; MEM_ACK = 1'b1; MEM_RDATA = 8'h4E;
        @(negedge CLK); MEM_ACK = 1'b0;
        chk("inflight_data", 32'(DOUT), 32'(e.data));
        bus_idle();
        @(negedge CLK); chk("inflight_release", 32'(BUSDIR_n), 32'd1);
        do_read(16'h4010, 8'h61, 2, 20'h04010);

        // Slot-bus reset during REQ: late acknowledge swallowed, banks cleared
        bank_wr(16'h6000, 8'h05);
        @(negedge CLK); ADDR = 16'h4010; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
        @(negedge CLK);
        chk("busrst_req", 32'(MEM_REQ), 32'd1);
        chk("busrst_addr", 32'(MEM_ADDR), 32'h0A010);
        RESET_n = 1'b0;
        @(negedge CLK);
        chk("busrst_req_drop", 32'(MEM_REQ), 32'd0);
        chk("busrst_wait", 32'(WAIT_n), 32'd1);
        chk("busrst_mem_addr", 32'(MEM_ADDR), 32'd0);
        RESET_n = 1'b1; bus_idle();
        @(negedge CLK);
        @(negedge CLK); MEM_ACK = 1'b1; MEM_RDATA = 8'h99;
        @(negedge CLK); MEM_ACK = 1'b0;
        chk("busrst_busdir", 32'(BUSDIR_n), 32'd1);
        chk("busrst_dout", 32'(DOUT), 32'd0);
        chk("busrst_no_req", 32'(MEM_REQ), 32'd0);
        do_read(16'h4010, 8'h12, 1, 20'h00010);

        // Drain with no acknowledge: reads ignored until the timeout expires
        bank_wr(16'h6000, 8'h05);
        @(negedge CLK); ADDR = 16'h4010; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
        @(negedge CLK); chk("drain_req", 32'(MEM_REQ), 32'd1); RESET_n = 1'b0;
        @(negedge CLK); RESET_n = 1'b1; bus_idle();
        no_resp(16'h4010, 1'b1);
        repeat (260) @(negedge CLK);
        do_read(16'h4010, 8'h34, 3, 20'h00010);

        // Synchronous reset while the bus is driven
        bank_wr(16'h6000, 8'h05);
        @(negedge CLK); ADDR = 16'h4000; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
        @(negedge CLK); MEM_ACK = 1'b1; MEM_RDATA = 8'h5C;
        @(negedge CLK); MEM_ACK = 1'b0;
        chk("hold_data", 32'(DOUT), 32'h5C);
        chk("hold_busdir", 32'(BUSDIR_n), 32'd0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("syncrst_busdir", 32'(BUSDIR_n), 32'd1);
        chk("syncrst_dout", 32'(DOUT), 32'd0);
        RESET = 1'b0; bus_idle();
        @(negedge CLK);
        do_read(16'h4000, 8'h0F, 1, 20'h00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
